// File: rtl/prewish_dipread.sv
// prewish_dipread: debounced active-low DIP reader answering masked snapshots over a strobe/ack handshake
module prewish_dipread #(
  parameter int TICK_BITS    = 14,
  parameter int STABLE_COUNT = 8,
  parameter int ALIVE_BITS   = 22
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       STB_I,
  input  logic [7:0] DAT_I,
  input  logic [7:0] i_dip,
  output logic       STB_O,
  output logic [7:0] DAT_O,
  output logic [7:0] o_chg,
  output logic       o_alive
);
  typedef enum logic [1:0] {IDLE, CAPTURE, ACK} state_t;
  localparam logic [3:0] LAST = 4'(STABLE_COUNT - 1);
  state_t                r_state, w_next;
  logic [7:0]            r_sync1, r_sync2, r_stable, r_mask, w_sw, w_tog;
  logic [3:0]            r_cnt [8];
  logic [TICK_BITS-1:0]  r_pre;
  logic [ALIVE_BITS-1:0] r_alive;
  logic                  w_tick;
  assign w_sw    = ~r_sync2;
  assign w_tick  = &r_pre;
  assign o_alive = r_alive[ALIVE_BITS-1];
  always_comb begin
    w_tog = '0;
    for (int i = 0; i < 8; i++)
      w_tog[i] = w_tick && (w_sw[i] != r_stable[i]) && (r_cnt[i] == LAST);
  end
  always_comb
    w_next = (r_state == IDLE) ? (STB_I ? CAPTURE : IDLE) : (r_state == CAPTURE) ? ACK : IDLE;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) r_state <= IDLE;
    else        r_state <= w_next;
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      r_sync1  <= 8'hFF;
      r_sync2  <= 8'hFF;
      r_stable <= '0;
      r_mask   <= '0;
      r_pre    <= '0;
      r_alive  <= '0;
      STB_O    <= 1'b0;
      DAT_O    <= '0;
      o_chg    <= '0;
      for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1  <= i_dip;
      r_sync2  <= r_sync1;
      r_pre    <= r_pre + 1'b1;
      r_alive  <= r_alive + 1'b1;
      // a matching level or an accepted change both restart the run
      for (int i = 0; i < 8; i++)
        if (w_tick) r_cnt[i] <= (w_sw[i] == r_stable[i] || w_tog[i]) ? 4'd0 : r_cnt[i] + 4'd1;
      r_stable <= r_stable ^ w_tog;
      if (r_state == IDLE && STB_I) r_mask <= DAT_I;
      STB_O <= (r_state == CAPTURE);
      if (r_state == CAPTURE) DAT_O <= r_stable & r_mask;
      o_chg <= (o_chg & ~((r_state == CAPTURE) ? r_mask : 8'h00)) | w_tog;
    end
endmodule
